fetch_stage: RTL and testbench

- Upstream neighbour of the combinational instruction ROM.
- Owns the program counter and drives the ROM address.
- Captures the returned instruction into the fetch/decode pipeline register.
- Handles stall, branch/jump redirect and fetch-fault detection (misaligned target, PC outside the ROM window).

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 95 +++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: ROM address/data, stall/redirect control and the F/D register outputs.
// The master modport is the fetch stage itself; the slave modport is its environment.
interface fetch_stage_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  stall_d_i;
  logic                  redirect_e_i;
  logic [DATA_WIDTH-1:0] target_e_i;
  logic [DATA_WIDTH-1:0] addr_f_o;
  logic [DATA_WIDTH-1:0] instr_f_i;
  logic [DATA_WIDTH-1:0] instr_d_o;
  logic [DATA_WIDTH-1:0] pc_d_o;
  logic [DATA_WIDTH-1:0] pc_plus4_d_o;
  logic                  valid_d_o;
  logic                  fault_d_o;

  modport master (
    input  stall_d_i, redirect_e_i, target_e_i, instr_f_i,
    output addr_f_o, instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o, fault_d_o
  );

  modport slave (
    output stall_d_i, redirect_e_i, target_e_i, instr_f_i,
    input  addr_f_o, instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o, fault_d_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, addresses the combinational ROM and fills the F/D register,
// handling stall, redirect and fetch faults (misaligned or outside the ROM window).
module fetch_stage #(
  parameter int unsigned          DATA_WIDTH       = 32,
  parameter logic [DATA_WIDTH-1:0] FIRST_INSTR_ADDR = 32'hBFC00000,
  parameter logic [DATA_WIDTH-1:0] LAST_INSTR_ADDR  = 32'hBFC00FFF,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR        = 32'h00000000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  fetch_stage_if.master bus
);

  // Last address at which a full word still lies inside the ROM.
  localparam logic [DATA_WIDTH-1:0] LastFetchAddr = LAST_INSTR_ADDR - DATA_WIDTH'(3);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] pc_d_q;
  logic [DATA_WIDTH-1:0] pc_plus4_d_q;
  logic                  valid_q;
  logic                  fault_q;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  fault_now;

  assign pc_plus4  = pc_q + DATA_WIDTH'(4);
  assign fault_now = (pc_q[1:0] != 2'b00) || (pc_q < FIRST_INSTR_ADDR) || (pc_q > LastFetchAddr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StRun;
      pc_q         <= FIRST_INSTR_ADDR;
      instr_q      <= NOP_INSTR;
      pc_d_q       <= '0;
      pc_plus4_d_q <= '0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.redirect_e_i) begin
            // Redirect overrides a stall: the wrong-path entry is squashed.
            pc_q    <= bus.target_e_i;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
          end else if (bus.stall_d_i) begin
            pc_q <= pc_q;
          end else if (fault_now) begin
            instr_q      <= NOP_INSTR;
            pc_d_q       <= pc_q;
            pc_plus4_d_q <= pc_plus4;
            valid_q      <= 1'b1;
            fault_q      <= 1'b1;
            state_q      <= StFault;
          end else begin
            instr_q      <= bus.instr_f_i;
            pc_d_q       <= pc_q;
            pc_plus4_d_q <= pc_plus4;
            valid_q      <= 1'b1;
            fault_q      <= 1'b0;
            pc_q         <= pc_plus4;
          end
        end
        StFault: begin
          if (bus.redirect_e_i) begin
            pc_q    <= bus.target_e_i;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            state_q <= StRun;
          end else if (!bus.stall_d_i) begin
            // Fault entry accepted: present bubbles until redirected.
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign bus.addr_f_o     = pc_q;
  assign bus.instr_d_o    = instr_q;
  assign bus.pc_d_o       = pc_d_q;
  assign bus.pc_plus4_d_o = pc_plus4_d_q;
  assign bus.valid_d_o    = valid_q;
  assign bus.fault_d_o    = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised and directed bench for fetch_stage against a behavioural fetch model
// with a synthetic ROM whose contents are a pure function of the address.
module tb_fetch_stage;

  localparam logic [31:0] First = 32'hBFC00000;
  localparam logic [31:0] Last  = 32'hBFC00FFF;
  localparam logic [31:0] Nop   = 32'h00000000;

  logic clk_i;
  logic rst_ni;
  int   n_checks;
  int   n_errors;

  fetch_stage_if #(.DATA_WIDTH(32)) bus ();

  fetch_stage #(
    .DATA_WIDTH      (32),
    .FIRST_INSTR_ADDR(First),
    .LAST_INSTR_ADDR (Last),
    .NOP_INSTR       (Nop)
  ) u_dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign bus.instr_f_i = rom_word(bus.addr_f_o);

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural model: fetch pointer, "stuck on a fault" flag and the entry decode sees.
  logic [31:0] m_pc, e_instr, e_pc, e_pc4;
  logic        m_stuck, e_valid, e_fault;

  function automatic bit fetchable(input logic [31:0] a);
    return (a % 4 == 0) && (a >= First) && (a + 3 <= Last) && (a <= 32'hFFFF_FFFC);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = First; m_stuck = 0;
    e_instr = Nop; e_pc = 0; e_pc4 = 0; e_valid = 0; e_fault = 0;
  endtask

  task automatic model_step(input bit stall, input bit redir, input logic [31:0] tgt);
    if (redir) begin
      m_pc = tgt; m_stuck = 0;
      e_instr = Nop; e_valid = 0; e_fault = 0;
    end else if (m_stuck) begin
      if (!stall) begin
        e_instr = Nop; e_valid = 0; e_fault = 0;
      end
    end else if (!stall) begin
      e_pc = m_pc; e_pc4 = m_pc + 4; e_valid = 1;
      if (fetchable(m_pc)) begin
        e_instr = rom_word(m_pc); e_fault = 0; m_pc = m_pc + 4;
      end else begin
        e_instr = Nop; e_fault = 1; m_stuck = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  bus.addr_f_o, m_pc);
    chk({tag, ".valid"}, {31'd0, bus.valid_d_o}, {31'd0, e_valid});
    chk({tag, ".fault"}, {31'd0, bus.fault_d_o}, {31'd0, e_fault});
    chk({tag, ".instr"}, bus.instr_d_o, e_instr);
    if (e_valid) begin
      chk({tag, ".pc"},   bus.pc_d_o, e_pc);
      chk({tag, ".pc4"},  bus.pc_plus4_d_o, e_pc4);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".addr"},  bus.addr_f_o, First);
    chk({tag, ".instr"}, bus.instr_d_o, Nop);
    chk({tag, ".pc"},    bus.pc_d_o, 32'd0);
    chk({tag, ".pc4"},   bus.pc_plus4_d_o, 32'd0);
    chk({tag, ".valid"}, {31'd0, bus.valid_d_o}, 32'd0);
    chk({tag, ".fault"}, {31'd0, bus.fault_d_o}, 32'd0);
  endtask

  task automatic cycle(input string tag, input bit stall, input bit redir, input logic [31:0] tgt);
    bus.stall_d_i    = stall;
    bus.redirect_e_i = redir;
    bus.target_e_i   = tgt;
    @(posedge clk_i);
    model_step(stall, redir, tgt);
    #1;
    check_all(tag);
  endtask

  function automatic logic [31:0] rand_target();
    int unsigned r;
    r = $urandom_range(0, 9);
    case (r)
      6:       return First + 32'($urandom_range(0, 4095));
      7:       return First - 32'($urandom_range(1, 16) * 4);
      8:       return 32'hBFC00FF0 + 32'($urandom_range(0, 4) * 4);
      9:       return (r[0] ? $urandom : 32'hFFFF_FFF8);
      default: return First + 32'($urandom_range(0, 1023) * 4);
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_ni = 1'b0;
    bus.stall_d_i = 1'b0;
    bus.redirect_e_i = 1'b0;
    bus.target_e_i = '0;
    model_reset();
    #12;
    check_reset("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Sequential fetch from the reset vector, then a 3-cycle stall at BFC00008.
    cycle("seq0", 0, 0, 0);
    chk("first_pc", bus.pc_d_o, First);
    cycle("seq1", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle("stall", 1, 0, 0);
      chk("stall_pc", bus.pc_d_o, 32'hBFC00004);
    end
    cycle("resume", 0, 0, 0);
    chk("resume_pc", bus.pc_d_o, 32'hBFC00008);
    cycle("seq3", 0, 0, 0);
    chk("seq3_pc", bus.pc_d_o, 32'hBFC0000C);

    // Redirect together with stall: bubble, then the target.
    cycle("redir_stall", 1, 1, 32'hBFC00100);
    chk("redir_bubble", {31'd0, bus.valid_d_o}, 32'd0);
    cycle("redir_tgt", 0, 0, 0);
    chk("redir_pc", bus.pc_d_o, 32'hBFC00100);

    // Misaligned target: one fault entry, then bubbles until redirected.
    cycle("mis_redir", 0, 1, 32'hBFC00102);
    cycle("mis_fault", 0, 0, 0);
    chk("mis_fault_flag", {31'd0, bus.fault_d_o}, 32'd1);
    chk("mis_fault_pc", bus.pc_d_o, 32'hBFC00102);
    cycle("mis_stall", 1, 0, 0);
    cycle("mis_bub0", 0, 0, 0);
    cycle("mis_bub1", 0, 0, 0);
    cycle("mis_fix", 0, 1, First);
    cycle("mis_rest", 0, 0, 0);
    chk("mis_rest_pc", bus.pc_d_o, First);

    // Running off the end of the ROM window.
    cycle("end_redir", 0, 1, 32'hBFC00FF8);
    cycle("end_ff8", 0, 0, 0);
    cycle("end_ffc", 0, 0, 0);
    chk("end_ffc_fault", {31'd0, bus.fault_d_o}, 32'd0);
    cycle("end_1000", 0, 0, 0);
    chk("end_1000_fault", {31'd0, bus.fault_d_o}, 32'd1);
    chk("end_1000_pc", bus.pc_d_o, 32'hBFC01000);
    cycle("end_hold", 0, 0, 0);
    chk("end_hold_addr", bus.addr_f_o, 32'hBFC01000);

    // Asynchronous reset mid-cycle while a valid entry is held.
    cycle("pre_rst_redir", 0, 1, 32'hBFC00040);
    cycle("pre_rst0", 0, 0, 0);
    cycle("pre_rst1", 0, 0, 0);
    #3;
    rst_ni = 1'b0;
    #1;
    check_reset("async_rst");
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle("post_rst", 0, 0, 0);
    chk("post_rst_pc", bus.pc_d_o, First);

    // Random stall/redirect traffic.
    for (int i = 0; i < 500; i++) begin
      bit st, rd;
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 9) == 0);
      cycle("rand", st, rd, rand_target());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
